jk_bank_sched: RTL

//   Shares one bank of WIDTH jk_ff cells between NREQ requesters.

---
 rtl/jk_bank_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing one bank of JK flip-flops between NREQ requesters.
// Accepted commands are registered into per-bit en/j/k; toggle bursts hold the bank.

module jk_ff (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end
endmodule

module jk_bank_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_mask,
  input  logic [CNT_W*NREQ-1:0]    req_cnt,
  output logic [WIDTH-1:0]         q,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  grant_id
);
  localparam int ID_W = $clog2(NREQ);

  // Handshake: a command transfers on a cycle where req_valid[i] & req_ready[i];
  // req_ready is combinational, one-hot, and only ever high in IDLE.
  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [WIDTH-1:0]  en_q, en_d;
  logic [WIDTH-1:0]  j_q, j_d;
  logic [WIDTH-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  rem_q, rem_d;

  logic              found;
  int                sel;
  int                idx;
  logic [1:0]        op;
  logic [WIDTH-1:0]  mask;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    en_d      = '0;
    j_d       = j_q;
    k_d       = k_q;
    rem_d     = rem_q;
    req_ready = '0;
    found     = 1'b0;
    sel       = 0;
    idx       = 0;
    op        = '0;
    mask      = '0;
    cnt       = '0;

    // First valid requester at or after rr_q, wrapping.
    for (int n = 0; n < NREQ; n++) begin
      idx = (int'(rr_q) + n) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end

    case (state_q)
      IDLE: begin
        if (found && reset_n) begin
          req_ready[sel] = 1'b1;
          gid_d = ID_W'(sel);
          rr_d  = (sel == NREQ - 1) ? '0 : ID_W'(sel + 1);
          op    = req_op[2*sel +: 2];
          mask  = req_mask[WIDTH*sel +: WIDTH];
          cnt   = req_cnt[CNT_W*sel +: CNT_W];
          en_d  = (op == 2'b00) ? '0 : mask;
          j_d   = {WIDTH{op[1]}};
          k_d   = {WIDTH{op[0]}};
          if (op == 2'b11 && cnt != '0) begin
            state_d = BURST;
            rem_d   = cnt;
          end
        end
      end
      BURST: begin
        // Re-issue the held toggle; the last repeat is loaded as we leave.
        en_d  = en_q;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      en_q    <= '0;
      j_q     <= '0;
      k_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      en_q    <= en_d;
      j_q     <= j_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
    end
  end

  logic bank_rst;
  assign bank_rst = ~reset_n;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bank
    jk_ff u_ff (
      .clk (clk),
      .rst (bank_rst),
      .en  (en_q[b]),
      .j   (j_q[b]),
      .k   (k_q[b]),
      .q   (q[b])
    );
  end

  assign busy     = (state_q == BURST);
  assign grant_id = gid_q;

endmodule
